// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce. Accepted keys shift into a 32-bit entry word,
// and a rising edge on enter commits that word as a one-cycle write strobe.
module hex_keypad_entry #(
  parameter int unsigned SCAN_DIV   = 2000,
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  input  logic        enter,
  input  logic        clr,
  output logic [31:0] value,
  output logic [3:0]  digits,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        wr_en,
  output logic [31:0] wr_data
);

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      pat_q, pat_d;
  logic [31:0]     value_q, value_d;
  logic [3:0]      digits_q, digits_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic [3:0]      row_s1_q, row_s2_q;
  logic            enter_s1_q, enter_s2_q, enter_prev_q;
  logic            clr_s1_q, clr_s2_q;
  logic            commit;
  logic [1:0]      row_sel;
  logic [3:0]      pressed_code;

  assign commit = enter_s2_q & ~enter_prev_q;

  // Lowest-index low row in the latched pattern wins.
  always_comb begin
    if (!pat_q[0])      row_sel = 2'd0;
    else if (!pat_q[1]) row_sel = 2'd1;
    else if (!pat_q[2]) row_sel = 2'd2;
    else                row_sel = 2'd3;
  end

  always_comb begin
    case ({row_sel, col_q})
      4'h0:    pressed_code = 4'h1;
      4'h1:    pressed_code = 4'h2;
      4'h2:    pressed_code = 4'h3;
      4'h3:    pressed_code = 4'hA;
      4'h4:    pressed_code = 4'h4;
      4'h5:    pressed_code = 4'h5;
      4'h6:    pressed_code = 4'h6;
      4'h7:    pressed_code = 4'hB;
      4'h8:    pressed_code = 4'h7;
      4'h9:    pressed_code = 4'h8;
      4'hA:    pressed_code = 4'h9;
      4'hB:    pressed_code = 4'hC;
      4'hC:    pressed_code = 4'hE;
      4'hD:    pressed_code = 4'h0;
      4'hE:    pressed_code = 4'hF;
      default: pressed_code = 4'hD;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    unique case (state_q)
      StScan: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (row_s2_q != 4'hF) begin
            state_d = StDebounce;
            pat_d   = row_s2_q;
            cnt_d   = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDebounce: begin
        if (row_s2_q != pat_q) begin
          state_d = StScan;
          cnt_d   = '0;
          div_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPressed: begin
        key_valid_d = 1'b1;
        key_code_d  = pressed_code;
        state_d     = StRelease;
        cnt_d       = '0;
      end
      StRelease: begin
        if (row_s2_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StScan;
          col_d   = col_q + 2'd1;
          div_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Entry word: clear beats commit beats key shift.
  always_comb begin
    value_d   = value_q;
    digits_d  = digits_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    if (clr_s2_q) begin
      value_d  = '0;
      digits_d = '0;
    end else if (commit) begin
      wr_en_d   = 1'b1;
      wr_data_d = value_q;
      value_d   = '0;
      digits_d  = '0;
    end else if (state_q == StPressed) begin
      value_d = {value_q[27:0], pressed_code};
      if (digits_q != 4'd8) digits_d = digits_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StScan;
      col_q        <= 2'd0;
      div_q        <= '0;
      cnt_q        <= '0;
      pat_q        <= 4'hF;
      value_q      <= '0;
      digits_q     <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      enter_s1_q   <= 1'b0;
      enter_s2_q   <= 1'b0;
      enter_prev_q <= 1'b0;
      clr_s1_q     <= 1'b0;
      clr_s2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      pat_q        <= pat_d;
      value_q      <= value_d;
      digits_q     <= digits_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      row_s1_q     <= row_n;
      row_s2_q     <= row_s1_q;
      enter_s1_q   <= enter;
      enter_s2_q   <= enter_s1_q;
      enter_prev_q <= enter_s2_q;
      clr_s1_q     <= clr;
      clr_s2_q     <= clr_s1_q;
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign value     = value_q;
  assign digits    = digits_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: keypad matrix model driving row_n from col_n, plus an
// arithmetic model of the entry word (shift-in, saturating digit count, clear/commit).
module tb_hex_keypad_entry;

  localparam int unsigned ScanDiv   = 4;
  localparam int unsigned DebCycles = 8;

  logic        clk = 1'b0;
  logic        reset, enter, clr;
  logic [3:0]  row_n, col_n, digits, key_code;
  logic [31:0] value, wr_data;
  logic        key_valid, wr_en;

  logic [15:0] pressed;  // bit r*4+c set while key (r,c) is held
  logic [3:0]  keymap [16];
  logic [31:0] exp_value;
  int          exp_digits;
  int          tests, fails;
  int          kv_count = 0;
  int          wr_count = 0;

  always #5 clk = ~clk;

  hex_keypad_entry #(.SCAN_DIV(ScanDiv), .DEB_CYCLES(DebCycles)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .enter     (enter),
    .clr       (clr),
    .value     (value),
    .digits    (digits),
    .key_valid (key_valid),
    .key_code  (key_code),
    .wr_en     (wr_en),
    .wr_data   (wr_data)
  );

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid === 1'b1) kv_count <= kv_count + 1;
    if (wr_en === 1'b1) wr_count <= wr_count + 1;
  end

  function automatic void model_key(input logic [3:0] code);
    exp_value = (exp_value << 4) | {28'd0, code};
    if (exp_digits < 8) exp_digits = exp_digits + 1;
  endfunction

  function automatic void model_clear();
    exp_value  = 32'd0;
    exp_digits = 0;
  endfunction

  task automatic press_key(input logic [3:0] code, input int hold,
                           output bit seen, output logic [3:0] got);
    int pos;
    int start;
    pos = 0;
    for (int i = 0; i < 16; i++) if (keymap[i] == code) pos = i;
    start = kv_count;
    seen = 1'b0;
    pressed[pos] = 1'b1;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (kv_count != start) seen = 1'b1;
    end
    got = key_code;
    repeat (hold) @(negedge clk);
    pressed[pos] = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_col_start(input int col);
    logic [3:0] tgt;
    tgt = ~(4'b0001 << col);
    for (int i = 0; i < 40 && col_n == tgt; i++) @(negedge clk);
    for (int i = 0; i < 40 && col_n != tgt; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    tests++; if (value !== 32'd0) begin fails++; $display("FAIL reset_value got %h want 0", value); end
    tests++; if (digits !== 4'd0) begin fails++; $display("FAIL reset_digits got %0d want 0", digits); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_kv got %b want 0", key_valid); end
    tests++; if (key_code !== 4'd0) begin fails++; $display("FAIL reset_code got %h want 0", key_code); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    tests++; if (wr_data !== 32'd0) begin fails++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / ScanDiv) % 4));
      tests++;
      if (col_n !== exp_col) begin
        fails++; $display("FAIL scan_col k=%0d got %b want %b", k, col_n, exp_col);
      end
    end
    tests++; if (kv_count != 0) begin fails++; $display("FAIL idle_kv got %0d want 0", kv_count); end
  endtask

  task automatic test_single_key();
    int start;
    start = kv_count;
    pressed[1*4+2] = 1'b1;
    repeat (40) @(negedge clk);
    pressed[1*4+2] = 1'b0;
    repeat (20) @(negedge clk);
    model_key(4'h6);
    tests++; if (kv_count - start != 1) begin fails++; $display("FAIL single_count got %0d want 1", kv_count - start); end
    tests++; if (key_code !== 4'h6) begin fails++; $display("FAIL single_code got %h want 6", key_code); end
    tests++; if (value !== exp_value) begin fails++; $display("FAIL single_value got %h want %h", value, exp_value); end
    tests++; if (digits !== 4'(exp_digits)) begin fails++; $display("FAIL single_digits got %0d want %0d", digits, exp_digits); end
  endtask

  task automatic test_sequence_commit();
    logic [3:0] seq [9];
    bit         seen;
    logic [3:0] got;
    int         wstart;
    seq = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB, 4'h7};
    model_clear();
    // Start from a committed-clean word so the 9th key demonstrates overflow.
    enter = 1'b1; repeat (4) @(negedge clk); enter = 1'b0; repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      press_key(seq[i], 5, seen, got);
      model_key(seq[i]);
      tests++; if (!seen || got !== seq[i]) begin
        fails++; $display("FAIL seq_key%0d got %h seen=%0d want %h", i, got, seen, seq[i]);
      end
    end
    tests++; if (value !== exp_value) begin fails++; $display("FAIL seq_value got %h want %h", value, exp_value); end
    tests++; if (digits !== 4'(exp_digits)) begin fails++; $display("FAIL seq_digits got %0d want %0d", digits, exp_digits); end
    wstart = wr_count;
    enter = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL commit_wr_en got %b want 1", wr_en); end
    tests++; if (wr_data !== exp_value) begin fails++; $display("FAIL commit_data got %h want %h", wr_data, exp_value); end
    tests++; if (value !== 32'd0 || digits !== 4'd0) begin
      fails++; $display("FAIL commit_clear got %h/%0d want 0/0", value, digits);
    end
    @(negedge clk);
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL commit_pulse got %b want 0", wr_en); end
    enter = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (wr_count - wstart != 1) begin fails++; $display("FAIL commit_count got %0d want 1", wr_count - wstart); end
    model_clear();
  endtask

  task automatic test_bounce();
    int start;
    start = kv_count;
    for (int i = 0; i < 10; i++) begin
      pressed[3*4+1] = ~pressed[3*4+1];
      repeat (3) @(negedge clk);
    end
    pressed[3*4+1] = 1'b1;
    repeat (40) @(negedge clk);
    pressed[3*4+1] = 1'b0;
    repeat (20) @(negedge clk);
    model_key(4'h0);
    tests++; if (kv_count - start != 1) begin fails++; $display("FAIL bounce_count got %0d want 1", kv_count - start); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL bounce_code got %h want 0", key_code); end
    tests++; if (digits !== 4'(exp_digits)) begin fails++; $display("FAIL bounce_digits got %0d want %0d", digits, exp_digits); end
    start = kv_count;
    pressed[3*4+1] = 1'b1;
    repeat (5) @(negedge clk);
    pressed[3*4+1] = 1'b0;
    repeat (30) @(negedge clk);
    tests++; if (kv_count - start != 0) begin fails++; $display("FAIL glitch_count got %0d want 0", kv_count - start); end
  endtask

  task automatic test_clear();
    bit         seen;
    logic [3:0] got;
    int         wstart;
    press_key(4'h5, 3, seen, got);
    model_key(4'h5);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    model_clear();
    tests++; if (value !== 32'd0 || digits !== 4'd0) begin
      fails++; $display("FAIL clr_value got %h/%0d want 0/0", value, digits);
    end
    press_key(4'hE, 3, seen, got);
    tests++; if (!seen || got !== 4'hE) begin fails++; $display("FAIL clr_key got %h seen=%0d want e", got, seen); end
    tests++; if (value !== 32'd0 || digits !== 4'd0) begin
      fails++; $display("FAIL clr_noshift got %h/%0d want 0/0", value, digits);
    end
    wstart = wr_count;
    enter = 1'b1; repeat (6) @(negedge clk); enter = 1'b0; repeat (3) @(negedge clk);
    tests++; if (wr_count != wstart) begin fails++; $display("FAIL clr_nowrite got %0d want 0", wr_count - wstart); end
    clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_commit_collision();
    bit         seen;
    logic [3:0] got;
    int         fc;
    int         start;
    press_key(4'h1, 3, seen, got); model_key(4'h1);
    press_key(4'h2, 3, seen, got); model_key(4'h2);
    tests++; if (value !== exp_value) begin fails++; $display("FAIL coll_pre got %h want %h", value, exp_value); end
    // Key 9 pressed at the start of column 2 reaches its accept cycle 12 clocks later;
    // enter rising 10 clocks after the press makes the commit land on that same cycle.
    wait_col_start(2);
    pressed[2*4+2] = 1'b1;
    repeat (10) @(negedge clk);
    enter = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (wr_en !== 1'b1 || wr_data !== exp_value) begin
      fails++; $display("FAIL coll_write got %b/%h want 1/%h", wr_en, wr_data, exp_value);
    end
    tests++; if (value !== 32'd0) begin fails++; $display("FAIL coll_value got %h want 0", value); end
    tests++; if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      fails++; $display("FAIL coll_key got %b/%h want 1/9", key_valid, key_code);
    end
    enter = 1'b0;
    repeat (10) @(negedge clk);
    pressed[2*4+2] = 1'b0;
    repeat (20) @(negedge clk);
    model_clear();
    tests++; if (value !== 32'd0) begin fails++; $display("FAIL coll_after got %h want 0", value); end
    fc = int'($urandom_range(0, 1));
    start = kv_count;
    wait_col_start(fc);
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    repeat (60) @(negedge clk);
    pressed[0] = 1'b0;
    pressed[1] = 1'b0;
    repeat (20) @(negedge clk);
    model_key(keymap[fc]);
    tests++; if (kv_count - start != 1) begin fails++; $display("FAIL dual_count got %0d want 1", kv_count - start); end
    tests++; if (key_code !== keymap[fc] || value !== exp_value) begin
      fails++; $display("FAIL dual_key got %h/%h want %h/%h", key_code, value, keymap[fc], exp_value);
    end
  endtask

  task automatic test_random_keys();
    bit         seen;
    logic [3:0] got;
    logic [3:0] code;
    int         n;
    int         wstart;
    n = int'($urandom_range(5, 11));
    for (int i = 0; i < n; i++) begin
      code = 4'($urandom_range(0, 15));
      press_key(code, int'($urandom_range(1, 20)), seen, got);
      model_key(code);
      tests++; if (!seen || got !== code) begin
        fails++; $display("FAIL rnd_key%0d got %h seen=%0d want %h", i, got, seen, code);
      end
    end
    tests++; if (value !== exp_value || digits !== 4'(exp_digits)) begin
      fails++; $display("FAIL rnd_word got %h/%0d want %h/%0d", value, digits, exp_value, exp_digits);
    end
    wstart = wr_count;
    enter = 1'b1;
    for (int i = 0; i < 10 && wr_count == wstart; i++) @(negedge clk);
    tests++; if (wr_count == wstart || wr_data !== exp_value) begin
      fails++; $display("FAIL rnd_commit got %h writes=%0d want %h", wr_data, wr_count - wstart, exp_value);
    end
    enter = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
  endtask

  task automatic test_reset_mid_press();
    bit         seen;
    logic [3:0] got;
    int         start;
    press_key(4'hA, 3, seen, got); model_key(4'hA);
    press_key(4'hB, 3, seen, got); model_key(4'hB);
    start = kv_count;
    pressed[2*4+3] = 1'b1;
    for (int i = 0; i < 80 && kv_count == start; i++) @(negedge clk);
    model_key(4'hC);
    tests++; if (value !== exp_value) begin fails++; $display("FAIL rmp_pre got %h want %h", value, exp_value); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    tests++; if (value !== 32'd0 || col_n !== 4'b1110 || digits !== 4'd0) begin
      fails++; $display("FAIL rmp_reset got %h/%b/%0d want 0/1110/0", value, col_n, digits);
    end
    start = kv_count;
    for (int i = 0; i < 80 && kv_count == start; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    pressed[2*4+3] = 1'b0;
    repeat (20) @(negedge clk);
    model_key(4'hC);
    tests++; if (kv_count - start != 1) begin fails++; $display("FAIL rmp_count got %0d want 1", kv_count - start); end
    tests++; if (key_code !== 4'hC || value !== exp_value || digits !== 4'(exp_digits)) begin
      fails++; $display("FAIL rmp_word got %h/%h/%0d want c/%h/%0d", key_code, value, digits, exp_value, exp_digits);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    enter   = 1'b0;
    clr     = 1'b0;
    pressed = '0;
    keymap  = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    model_clear();
    test_reset();
    test_single_key();
    test_sequence_commit();
    test_bounce();
    test_clear();
    test_commit_collision();
    test_random_keys();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
